param_message_queue: RTL
========================

Name: param_message_queue

Overview:
Parametrised PACKET2MESSAGE-stage queue. It accepts whole packets from the input-port flit buffers and holds them in a circular FIFO of DEPTH entries. It presents the head message to the wb_master_interface as a WISHBONE burst. Compared with the previous generation it adds configurable depth and widths, per-beat byte selects derived from flit validity, occupancy/full/empty status, and a bounded-retry abort with an error pulse.

Parameters:
DEPTH, 4, number of message slots; any value >= 2, not required to be a power of two.
MAX_PKT_FLITS, 5, maximum flits per packet, head included.
FLIT_WIDTH, 32, flit width; also the bus data width (one beat = one flit).
ADDR_WIDTH, 24, bus address width; FLIT_WIDTH >= ADDR_WIDTH+4.
MAX_RETRY, 3, retries tolerated before the head message is aborted; >= 1.
N_BITS_BURST_LENGHT, 7, width of burst_lenght_o.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_link_i  in  MAX_PKT_FLITS*FLIT_WIDTH  packet flits; flit 0 in the LSBs
in_sel_i  in  MAX_PKT_FLITS  flit-valid mask; bit 0 (head) is always 1
r_pkt_to_msg_i  in  1  storage request; held with in_link_i/in_sel_i stable until granted
g_pkt_to_msg_o  out  1  one-cycle grant; data is captured on the clock edge that ends the grant cycle
r_bus_arbitration_o  out  1  head message valid, request the bus
address_o  out  ADDR_WIDTH  head flit bits [ADDR_WIDTH+3:4]
data_o  out  FLIT_WIDTH  current beat data
sel_o  out  FLIT_WIDTH/8  current beat byte selects
transaction_type_o  out  1  1 = write, 0 = read
burst_lenght_o  out  N_BITS_BURST_LENGHT  beats in the current message
next_data_i  in  1  advance to the next beat
retry_i  in  1  restart the current message
message_transmitted_i  in  1  head message completed, pop it
count_o  out  clog2(DEPTH+1)  occupancy
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0
error_o  out  1  one-cycle pulse when the head message is aborted

Behaviour:
- Reset values: count_o=0, g_pkt_to_msg_o=0, error_o=0, all pointers and the retry counter 0, empty_o=1, full_o=0, r_bus_arbitration_o=0. Reset mid-burst drops all messages; slot storage is not cleared.
- Grant: registered. Next-cycle g=1 iff r_pkt_to_msg_i && !g && count_o<DEPTH. Grant is never asserted two cycles in a row.
- Store on g=1: head flit, all flits and in_sel_i[MAX_PKT_FLITS-1:1] are written to the tail slot. Tail increments and wraps DEPTH-1 -> 0.
- Head flit decode:
  - Bits [1:0] are the type; 2'b11 = HEAD_TAIL.
  - Bits [3:2] are the cmd: 00 = read, 01 = write, 10 = control.
  - Read is a HEAD_TAIL flit with cmd 00 -> transaction_type_o=0; every other case -> 1.
- Burst length:
  - Control write: 1 beat, data = head flit, sel all ones.
  - Other write: popcount of the stored body mask (minimum 1), data = flits 1..N.
  - Read: MAX_PKT_FLITS-1 beats, sel all ones.
- Write sel_o: all ones if the body-mask bit for the current beat is set, else 0.
- Beat pointer:
  - Cleared on message_transmitted_i or retry_i; otherwise +1 on next_data_i.
  - Saturates at burst_lenght_o-1.
  - data_o and sel_o are combinational from the head slot and the beat pointer.
- Pop: message_transmitted_i && !empty_o advances head with wrap. message_transmitted_i while empty is ignored.
- Simultaneous store and pop: count_o is unchanged and both pointers advance.
- Retry:
  - retry_i increments the retry counter.
  - When the counter reaches MAX_RETRY on a retry, the head message is popped instead, error_o pulses 1 cycle, and the counter clears.
  - The counter also clears on any pop.
  - If message_transmitted_i and retry_i arrive together, transmitted wins and the counter is not incremented.
  - retry_i while empty is ignored.
- r_bus_arbitration_o = !empty_o.

Test Plan:
- Reset, then a write packet with in_sel=5'b00111 and cmd 01 -> grant 1 cycle after request; next cycle count_o=1, burst_lenght_o=2, transaction_type_o=1, data_o=flit1, then flit2 after next_data_i.
- Fill DEPTH=4 with requests held high -> 4 grants, full_o=1, 5th request gets no grant until message_transmitted_i; grant follows 1 cycle after count_o drops to 3.
- Store and pop in the same cycle with count_o=2 -> count_o stays 2 and tail/head wrap correctly after 6 messages.
- HEAD_TAIL flit with cmd 00 -> transaction_type_o=0, burst_lenght_o=4, sel_o=4'hF. HEAD_TAIL flit with cmd 10 -> burst 1, data_o=head flit.
- Three consecutive retry_i with MAX_RETRY=3 -> 3rd retry pops the head, error_o=1 for 1 cycle, count_o decrements, beat pointer is 0.
- Assert rst mid-burst with count_o=3 -> next cycle count_o=0, empty_o=1, r_bus_arbitration_o=0, g_pkt_to_msg_o=0.

Source files
------------

// File: rtl/param_message_queue.sv
`default_nettype none
// ============================================================================
// Module   : param_message_queue
// Purpose  : Circular FIFO of whole packets, replayed as WISHBONE bursts with
//            per-beat byte selects, occupancy status and bounded-retry abort.
// Revision : 1.0 - initial release
// ============================================================================
module param_message_queue #(
    parameter int DEPTH               = 4,
    parameter int MAX_PKT_FLITS       = 5,
    parameter int FLIT_WIDTH          = 32,
    parameter int ADDR_WIDTH          = 24,
    parameter int MAX_RETRY           = 3,
    parameter int N_BITS_BURST_LENGHT = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [MAX_PKT_FLITS*FLIT_WIDTH-1:0]   in_link_i,
    input  logic [MAX_PKT_FLITS-1:0]              in_sel_i,
    input  logic                                  r_pkt_to_msg_i,
    output logic                                  g_pkt_to_msg_o,
    output logic                                  r_bus_arbitration_o,
    output logic [ADDR_WIDTH-1:0]                 address_o,
    output logic [FLIT_WIDTH-1:0]                 data_o,
    output logic [FLIT_WIDTH/8-1:0]               sel_o,
    output logic                                  transaction_type_o,
    output logic [N_BITS_BURST_LENGHT-1:0]        burst_lenght_o,
    input  logic                                  next_data_i,
    input  logic                                  retry_i,
    input  logic                                  message_transmitted_i,
    output logic [$clog2(DEPTH+1)-1:0]            count_o,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic                                  error_o
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH+1);
    localparam int c_fidx_w = $clog2(MAX_PKT_FLITS);
    localparam int c_rty_w  = $clog2(MAX_RETRY+1);
    localparam int c_sel_w  = FLIT_WIDTH/8;
    localparam int c_bl_w   = N_BITS_BURST_LENGHT;
    localparam logic [c_ptr_w-1:0] c_last_slot = c_ptr_w'(DEPTH-1);

    // Slot storage (never reset: only the pointers define validity)
    logic [FLIT_WIDTH-1:0]    r_mem  [DEPTH][MAX_PKT_FLITS];
    logic [MAX_PKT_FLITS-1:0] r_mask [DEPTH];

    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_rty_w-1:0]  r_retry;
    logic [c_fidx_w-1:0] r_beat;
    logic                r_grant;
    logic                r_error;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_store;
    logic                     w_pop;
    logic                     w_abort;
    logic [FLIT_WIDTH-1:0]    w_head_flit;
    logic [MAX_PKT_FLITS-1:0] w_head_mask;
    logic                     w_is_read;
    logic                     w_is_ctrl;
    logic [c_bl_w-1:0]        w_body_cnt;
    logic [c_bl_w-1:0]        w_burst_len;
    logic [c_fidx_w-1:0]      w_flit_idx;
    logic                     w_unused_sel0;

    assign w_unused_sel0 = in_sel_i[0];

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_store = r_grant;
    // A retry that would reach MAX_RETRY aborts the head instead of replaying it
    assign w_abort = retry_i && !message_transmitted_i && !w_empty &&
                     (r_retry == c_rty_w'(MAX_RETRY-1));
    assign w_pop   = !w_empty && (message_transmitted_i || w_abort);

    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int f = 0; f < MAX_PKT_FLITS; f++) begin
                r_mem[r_tail][f] <= in_link_i[f*FLIT_WIDTH +: FLIT_WIDTH];
            end
            r_mask[r_tail] <= {in_sel_i[MAX_PKT_FLITS-1:1], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_retry <= '0;
            r_beat  <= '0;
            r_grant <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_grant <= r_pkt_to_msg_i && !r_grant && !w_full;
            r_error <= w_abort;

            if (w_store) begin
                r_tail <= (r_tail == c_last_slot) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= (r_head == c_last_slot) ? '0 : r_head + 1'b1;
            end

            if (w_store && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_store) begin
                r_count <= r_count - 1'b1;
            end

            if (w_pop) begin
                r_retry <= '0;
            end else if (retry_i && !w_empty) begin
                r_retry <= r_retry + 1'b1;
            end

            if (message_transmitted_i || retry_i) begin
                r_beat <= '0;
            end else if (next_data_i &&
                         (c_bl_w'(r_beat) + c_bl_w'(1) < w_burst_len)) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    assign w_head_flit = r_mem[r_head][0];
    assign w_head_mask = r_mask[r_head];
    assign w_is_read   = (w_head_flit[1:0] == 2'b11) && (w_head_flit[3:2] == 2'b00);
    assign w_is_ctrl   = (w_head_flit[3:2] == 2'b10);
    assign w_flit_idx  = r_beat + c_fidx_w'(1);

    always_comb begin
        w_body_cnt = '0;
        for (int f = 1; f < MAX_PKT_FLITS; f++) begin
            w_body_cnt = w_body_cnt + c_bl_w'(w_head_mask[f]);
        end
    end

    always_comb begin
        w_burst_len = w_body_cnt;
        if (w_is_read) begin
            w_burst_len = c_bl_w'(MAX_PKT_FLITS-1);
        end else if (w_is_ctrl || (w_body_cnt == '0)) begin
            w_burst_len = c_bl_w'(1);
        end
    end

    always_comb begin
        data_o = r_mem[r_head][w_flit_idx];
        sel_o  = {c_sel_w{1'b1}};
        if (w_is_ctrl) begin
            data_o = w_head_flit;
        end else if (!w_is_read) begin
            sel_o = {c_sel_w{w_head_mask[w_flit_idx]}};
        end
    end

    assign g_pkt_to_msg_o      = r_grant;
    assign error_o             = r_error;
    assign count_o             = r_count;
    assign full_o              = w_full;
    assign empty_o             = w_empty;
    assign r_bus_arbitration_o = !w_empty;
    assign address_o           = w_head_flit[ADDR_WIDTH+3:4];
    assign transaction_type_o  = !w_is_read;
    assign burst_lenght_o      = w_burst_len;

endmodule
`default_nettype wire
